// File: rtl/fma_seq_pkg.sv
// Shared encodings for the FMA issue sequencer: op codes, rounding modes
// and the rounding-mode legality check.
package fma_seq_pkg;

  typedef enum logic [1:0] {
    FMADD  = 2'b00,
    FMSUB  = 2'b01,
    FNMSUB = 2'b10,
    FNMADD = 2'b11
  } op_e;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;

  // Only the five IEEE modes are legal once the dynamic mode is resolved.
  function automatic logic frm_legal(input logic [2:0] frm);
    return (frm <= RMM);
  endfunction

endpackage

// File: rtl/fma_seq_stage.sv
// One pipeline slot of the FMA sequencer: valid, tag, rounding mode and
// illegal-mode flag, with load, drain and flush-clear.
module fma_seq_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic             drain,
  input  logic [TAG_W-1:0] d_tag,
  input  logic [2:0]       d_frm,
  input  logic             d_illegal,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [2:0]       frm,
  output logic             illegal
);

  // Flush beats everything; a load replaces contents, a drain leaves a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= 1'b0;
      tag     <= '0;
      frm     <= 3'b000;
      illegal <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      tag     <= d_tag;
      frm     <= d_frm;
      illegal <= d_illegal;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fma_seq.sv
// In-order issue/pipeline sequencer for the pipelined FMA datapath.
// Optional performance counters are built when FMA_SEQ_PERF_EN is defined.
module fma_seq
  import fma_seq_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [2:0]        req_frm,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [2:0]        csr_frm,
  input  logic              flush,
  output logic [STAGES-1:0] stg_en,
  output logic              neg_prod,
  output logic              neg_add,
  output logic              rm_neg,
  output logic [2:0]        frm_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_illegal,
  output logic              busy,
  output logic [31:0]       perf_issue,
  output logic [31:0]       perf_stall
);

  logic [STAGES-1:0] v_s;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] load_s;
  logic [TAG_W-1:0]  tag_s     [STAGES];
  logic [2:0]        frm_s     [STAGES];
  logic              ill_s     [STAGES];
  logic [TAG_W-1:0]  d_tag_s   [STAGES];
  logic [2:0]        d_frm_s   [STAGES];
  logic              d_ill_s   [STAGES];
  logic              accept_s;
  logic [2:0]        eff_frm_s;
  op_e               op_s;

  assign op_s      = op_e'(req_op);
  assign eff_frm_s = (req_frm == DYN) ? csr_frm : req_frm;

  // Advance chain runs from the output back to stage 0 so bubbles compress.
  always_comb begin
    logic [STAGES-1:0] a;
    a = '0;
    a[STAGES-1] = v_s[STAGES-1] & rsp_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      a[i] = v_s[i] & (~v_s[i+1] | a[i+1]);
    end
    adv_s = a;
  end

  // Ready is gated by reset_n so the port reads 0 while reset is held.
  assign req_ready = reset_n & ~flush & (~v_s[0] | adv_s[0]);
  assign accept_s  = req_valid & req_ready;
  assign load_s    = {adv_s[STAGES-2:0], accept_s};
  assign stg_en    = load_s & {STAGES{~flush}};

  assign neg_prod = accept_s & ((op_s == FNMSUB) | (op_s == FNMADD));
  assign neg_add  = accept_s & ((op_s == FMSUB)  | (op_s == FNMADD));

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign d_tag_s[g] = req_tag;
      assign d_frm_s[g] = eff_frm_s;
      assign d_ill_s[g] = ~frm_legal(eff_frm_s);
    end else begin : g_body
      assign d_tag_s[g] = tag_s[g-1];
      assign d_frm_s[g] = frm_s[g-1];
      assign d_ill_s[g] = ill_s[g-1];
    end

    fma_seq_stage #(.TAG_W(TAG_W)) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (flush),
      .load      (load_s[g]),
      .drain     (adv_s[g]),
      .d_tag     (d_tag_s[g]),
      .d_frm     (d_frm_s[g]),
      .d_illegal (d_ill_s[g]),
      .valid     (v_s[g]),
      .tag       (tag_s[g]),
      .frm       (frm_s[g]),
      .illegal   (ill_s[g])
    );
  end

  assign rsp_valid   = v_s[STAGES-1] & ~flush;
  assign rsp_tag     = tag_s[STAGES-1];
  assign rsp_illegal = ill_s[STAGES-1];
  assign frm_out     = frm_s[STAGES-1];
  assign rm_neg      = (frm_s[STAGES-1] == RDN);
  assign busy        = |v_s;

`ifdef FMA_SEQ_PERF_EN
  logic [31:0] issue_cnt_r;
  logic [31:0] stall_cnt_r;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (accept_s) begin
        issue_cnt_r <= issue_cnt_r + 32'd1;
      end
      if (v_s[STAGES-1] & ~rsp_ready & ~flush) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign perf_issue = issue_cnt_r;
  assign perf_stall = stall_cnt_r;
`else
  assign perf_issue = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_fma_seq.sv
// Directed, scoreboard-checked bench for fma_seq (STAGES=3, TAG_W=5).
module tb_fma_seq;

  typedef struct packed {
    logic [4:0] tag;
    logic [2:0] frm;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [2:0] req_frm, csr_frm;
  logic [4:0] req_tag;
  logic       flush;
  logic [2:0] stg_en;
  logic       neg_prod, neg_add, rm_neg;
  logic [2:0] frm_out;
  logic       rsp_valid, rsp_ready;
  logic [4:0] rsp_tag;
  logic       rsp_illegal, busy;
  logic [31:0] perf_issue, perf_stall;

  int   errors = 0;
  int   checks = 0;
  int   exp_issue = 0;
  int   exp_stall = 0;
  exp_t sb[$];

  fma_seq #(.TAG_W(5), .STAGES(3)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_frm(req_frm), .req_tag(req_tag), .csr_frm(csr_frm),
    .flush(flush), .stg_en(stg_en), .neg_prod(neg_prod), .neg_add(neg_add),
    .rm_neg(rm_neg), .frm_out(frm_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy),
    .perf_issue(perf_issue), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] frm, input logic [4:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_frm   = frm;
    req_tag   = tag;
  endtask

  // Scoreboard update at the falling edge, then advance to just after the rising edge.
  task automatic tick();
    exp_t       e;
    logic [2:0] eff;
    @(negedge clk);
    if (reset_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (req_valid && req_ready) begin
          eff = (req_frm == 3'b111) ? csr_frm : req_frm;
          e.tag = req_tag;
          e.frm = eff;
          e.ill = (eff >= 3'b101);
          sb.push_back(e);
          exp_issue++;
        end
        if (rsp_valid && !rsp_ready) exp_stall++;
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_with_empty_scoreboard", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            check("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
            check("frm_out", 32'(frm_out), 32'(e.frm));
            check("rm_neg", 32'(rm_neg), 32'(e.frm == 3'b010));
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_perf(input string name);
`ifdef FMA_SEQ_PERF_EN
    check({name, "_issue"}, perf_issue, 32'(exp_issue));
    check({name, "_stall"}, perf_stall, 32'(exp_stall));
`else
    check({name, "_issue"}, perf_issue, 32'd0);
    check({name, "_stall"}, perf_stall, 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_frm = 3'b000;
    req_tag = 5'd0; csr_frm = 3'b000; flush = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stg_en", 32'(stg_en), 32'd0);
    check_perf("reset_perf");
    reset_n = 1'b1;
    #1;
    check("release_req_ready", 32'(req_ready), 32'd1);
    tick();

    // Single fmadd, no backpressure: response exactly three cycles later.
    send(2'b00, 3'b000, 5'd5);
    #1;
    check("t1_neg_prod", 32'(neg_prod), 32'd0);
    check("t1_neg_add", 32'(neg_add), 32'd0);
    check("t1_stg_en", 32'(stg_en), 32'b001);
    tick();
    req_valid = 1'b0;
    check("t1_lat_c1", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_lat_c2", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_lat_c3", 32'(rsp_valid), 32'd1);
    drain();

    // Back-to-back with the consumer blocked until the pipe fills.
    send(2'b00, 3'b000, 5'd1); #1; tick();
    send(2'b00, 3'b000, 5'd2); rsp_ready = 1'b0; #1; tick();
    send(2'b00, 3'b001, 5'd3); #1; tick();
    send(2'b00, 3'b011, 5'd4); #1;
    check("t2_full_ready", 32'(req_ready), 32'd0);
    check("t2_full_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_full_tag", 32'(rsp_tag), 32'd1);
    tick();
    check("t2_stall_ready", 32'(req_ready), 32'd0);
    check("t2_stall_tag", 32'(rsp_tag), 32'd1);
    check("t2_stall_frm", 32'(frm_out), 32'b000);
    tick();
    rsp_ready = 1'b1; #1;
    check("t2_release_ready", 32'(req_ready), 32'd1);
    check("t2_release_stg_en", 32'(stg_en), 32'b111);
    check("t2_release_busy", 32'(busy), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_one_per_cycle", 32'(rsp_valid), 32'd1);
      tick();
    end
    check("t2_empty", 32'(rsp_valid), 32'd0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    check_perf("t2_perf");

    // Dynamic rounding mode, illegal mode, and operand sign controls.
    csr_frm = 3'b010; send(2'b00, 3'b111, 5'd7); #1; tick();
    csr_frm = 3'b110; send(2'b00, 3'b111, 5'd8); #1; tick();
    csr_frm = 3'b000; send(2'b11, 3'b000, 5'd9); #1;
    check("t3_fnmadd_neg_prod", 32'(neg_prod), 32'd1);
    check("t3_fnmadd_neg_add", 32'(neg_add), 32'd1);
    tick();
    send(2'b01, 3'b001, 5'd10); #1;
    check("t3_fmsub_neg_prod", 32'(neg_prod), 32'd0);
    check("t3_fmsub_neg_add", 32'(neg_add), 32'd1);
    tick();
    send(2'b10, 3'b100, 5'd11); #1;
    check("t3_fnmsub_neg_prod", 32'(neg_prod), 32'd1);
    check("t3_fnmsub_neg_add", 32'(neg_add), 32'd0);
    tick();
    req_valid = 1'b0; #1;
    check("t3_idle_neg_prod", 32'(neg_prod), 32'd0);
    drain();

    // Flush with three ops in flight and a request waiting.
    send(2'b00, 3'b000, 5'd12); #1; tick();
    send(2'b00, 3'b000, 5'd13); #1; tick();
    send(2'b00, 3'b000, 5'd14); #1; tick();
    flush = 1'b1; send(2'b11, 3'b000, 5'd15); #1;
    check("t4_flush_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t4_flush_req_ready", 32'(req_ready), 32'd0);
    check("t4_flush_neg_prod", 32'(neg_prod), 32'd0);
    check("t4_flush_stg_en", 32'(stg_en), 32'd0);
    check("t4_flush_busy_before", 32'(busy), 32'd1);
    tick();
    flush = 1'b0; #1;
    check("t4_post_busy", 32'(busy), 32'd0);
    check("t4_post_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    drain();
    check_perf("t4_perf");

    // Asynchronous reset in the middle of traffic.
    send(2'b00, 3'b000, 5'd20); #1; tick();
    send(2'b01, 3'b010, 5'd21); #1; tick();
    send(2'b11, 3'b010, 5'd22);
    reset_n = 1'b0; #1;
    check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_req_ready", 32'(req_ready), 32'd0);
    check("t5_rst_neg_prod", 32'(neg_prod), 32'd0);
    check("t5_rst_stg_en", 32'(stg_en), 32'd0);
    check("t5_rst_frm_out", 32'(frm_out), 32'd0);
    check("t5_rst_rm_neg", 32'(rm_neg), 32'd0);
    check("t5_rst_rsp_tag", 32'(rsp_tag), 32'd0);
    sb.delete(); exp_issue = 0; exp_stall = 0;
    check_perf("t5_rst_perf");
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b1; #1;
    check("t5_release_ready", 32'(req_ready), 32'd1);
    send(2'b00, 3'b011, 5'd23); #1; tick();
    req_valid = 1'b0;
    drain();
    check_perf("t5_final_perf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fma_seq.md
Name: fma_seq

Overview:
- In-order issue/pipeline sequencer for the pipelined FMA datapath (multiplier, aligner, adder, sign/round logic).
- Accepts FMA requests over a valid/ready handshake and resolves the effective rounding mode.
- Drives per-stage enables and per-op sign controls into the datapath.
- Returns tagged responses over a valid/ready handshake with backpressure and flush.

Parameters:
- TAG_W, 5, width of request/response tag.
- STAGES, 3, datapath pipeline depth; legal range 2..4.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_op  in  2  00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd.
- req_frm  in  3  instruction rounding mode; 111 = dynamic.
- req_tag  in  TAG_W  request tag.
- csr_frm  in  3  dynamic rounding mode from the FCSR.
- flush  in  1  kill all in-flight ops.
- stg_en  out  STAGES  datapath stage register enables.
- neg_prod  out  1  stage-0 product sign flip (ops 10, 11).
- neg_add  out  1  stage-0 addend sign flip (ops 01, 11).
- rm_neg  out  1  last stage: effective frm == 010 (round toward minus infinity) to the sign logic.
- frm_out  out  3  last-stage effective rounding mode.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_tag  out  TAG_W  response tag.
- rsp_illegal  out  1  op had an illegal rounding mode.
- busy  out  1  any stage valid.
- perf_issue  out  32  issued-op count.
- perf_stall  out  32  backpressure-stall cycle count.

Behaviour:
- Reset (async, reset_n low): all stage valid bits, tags, frm and illegal flags cleared; all outputs 0. req_ready is 0 during reset and 1 in the first cycle after release.
- Effective frm: req_frm when != 111, else csr_frm, sampled at acceptance.
- Illegal frm: effective value in {101, 110, 111}.
  - The op still occupies the pipeline and carries its tag, with illegal=1.
  - stg_en for that op's slots is still asserted; the datapath result is ignored downstream.
- Per-stage state: valid, tag, frm, illegal.
- Advance rule:
  - adv[S-1] = v[S-1] & rsp_ready.
  - adv[i] = v[i] & (~v[i+1] | adv[i+1]).
  - stg_en[i] = 1 when stage i loads new contents.
- req_ready = ~flush & (~v[0] | adv[0]). Ready is combinational from rsp_ready through the stage chain; there is no combinational path from req_valid.
- Latency: accepted in cycle c, rsp_valid in cycle c+STAGES with no backpressure. Throughput is 1 op/cycle.
- Backpressure:
  - rsp_valid held with rsp_valid & ~rsp_ready: last stage holds and bubbles compress upstream.
  - Full pipeline with blocked output: req_ready = 0.
  - rsp_tag, rsp_illegal and frm_out stay stable while stalled.
- rsp_valid = v[S-1] & ~flush.
- Flush:
  - All valid bits clear on the next edge.
  - No request is accepted in the flush cycle, and no response is delivered in that cycle.
  - Ops accepted after flush deassertion proceed normally.
- Simultaneous accept and response at full occupancy: both occur, and occupancy stays constant.
- neg_prod/neg_add are combinational from req_op, qualified by the req_valid & req_ready handshake; 0 otherwise.
- busy = OR of valid bits.

Optional Feature:
- FMA_SEQ_PERF_EN defined:
  - perf_issue increments per accepted request.
  - perf_stall increments per cycle with v[S-1] & ~rsp_ready & ~flush.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by reset only (not by flush).
- Undefined: no counter flops; perf_issue and perf_stall are tied to 0.

Decomposition:
- Package fma_seq_pkg:
  - op encodings FMADD, FMSUB, FNMSUB, FNMADD.
  - frm constants RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111.
  - function frm_legal.
- Sub-module fma_seq_stage: one stage slot (valid, tag, frm, illegal flops with load/clear), instantiated STAGES times via generate.

Test Plan:
- STAGES=3, rsp_ready=1; fmadd tag=5, frm=000 accepted in cycle 10 -> rsp_valid in cycle 13, rsp_tag=5, rsp_illegal=0, frm_out=000, neg_prod=0 and neg_add=0 in cycle 10.
- Back-to-back tags 1,2,3,4 with rsp_ready low from cycle 2 -> req_ready drops once 3 slots are full. Raise rsp_ready -> tags return 1,2,3,4 in order, no loss or duplication, 1 per cycle.
- req_frm=111 with csr_frm=010 -> frm_out=010 and rm_neg=1 on response. csr_frm=110 -> rsp_illegal=1, tag preserved.
- fnmadd accepted -> neg_prod=1, neg_add=1. fmsub accepted -> neg_prod=0, neg_add=1.
- 3 ops in flight, flush for 1 cycle -> rsp_valid=0 that cycle, busy=0 next cycle. A new op in the flush cycle is not accepted; the same op is accepted in the next cycle and returns normally.
- reset_n pulled low mid-stream -> all outputs 0 immediately, asynchronously. With FMA_SEQ_PERF_EN: 4 issues plus 2 stall cycles -> perf_issue=4, perf_stall=2; both 0 after reset.
